// File: rtl/sqrt_req_master.sv
// sqrt_req_master
// Issues a run of pseudo-random operands to a square-root unit over a strobe/ack
// handshake and collects one result per operand. Operands come from a 32-bit
// Galois LFSR (polynomial 32'h80200003) that is seeded at the start of each run.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst        : asynchronous reset, active low
//   start      : one-cycle run request (ignored while busy)
//   count      : operands in the run, sampled with start
//   seed       : LFSR seed, sampled with start (zero is replaced by 1)
//   out_a      : operand to the sqrt unit
//   out_a_stb  : operand valid
//   out_a_ack  : sqrt unit accepts operand
//   in_z       : result from the sqrt unit
//   in_z_stb   : result valid
//   in_z_ack   : result accepted (one-cycle pulse)
//   res_a      : operand of the last completed transaction
//   res_z      : result of the last completed transaction
//   res_valid  : one-cycle pulse when res_a/res_z update
//   busy       : run in progress
//   done       : one-cycle end-of-run pulse
//   err        : sticky watchdog timeout flag (cleared by the next start)
//
// Optional feature: define SQRT_REQ_MASTER_TIMEOUT_EN to add a watchdog that
// abandons a run when a handshake wait reaches TIMEOUT_CYCLES clocks. Without
// the macro there is no watchdog and err is tied to 0.
module sqrt_req_master #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  count,
    input  logic [31:0] seed,
    output logic [31:0] out_a,
    output logic        out_a_stb,
    input  logic        out_a_ack,
    input  logic [31:0] in_z,
    input  logic        in_z_stb,
    output logic        in_z_ack,
    output logic [31:0] res_a,
    output logic [31:0] res_z,
    output logic        res_valid,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_RES,
        ACK,
        DONE
    } state_t;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    state_t      state, state_d;
    logic [31:0] lfsr, lfsr_d;
    logic [31:0] operand, operand_d;
    logic [7:0]  remaining, remaining_d;
    logic [31:0] out_a_d, res_a_d, res_z_d;
    logic        out_a_stb_d, in_z_ack_d, res_valid_d, busy_d, done_d;

`ifdef SQRT_REQ_MASTER_TIMEOUT_EN
    logic [15:0] wdog, wdog_d;
    logic        wdog_hit;
    logic        err_d;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign err = 1'b0;
`endif

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

    // Next-state and next-output logic. Every output is registered, so the
    // values presented while in a state are decided on the transition into it.
    always_comb begin
        state_d     = state;
        lfsr_d      = lfsr;
        operand_d   = operand;
        remaining_d = remaining;
        out_a_d     = out_a;
        out_a_stb_d = out_a_stb;
        in_z_ack_d  = 1'b0;
        res_a_d     = res_a;
        res_z_d     = res_z;
        res_valid_d = 1'b0;
        busy_d      = busy;
        done_d      = 1'b0;
`ifdef SQRT_REQ_MASTER_TIMEOUT_EN
        err_d       = err;
        wdog_d      = wdog;
        // the wait has lasted TIMEOUT_CYCLES clocks once this edge is taken
        wdog_hit    = (wdog == (TIMEOUT_CYCLES - 16'd1));
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    lfsr_d      = (seed == 32'd0) ? 32'h00000001 : seed;
                    remaining_d = count;
                    busy_d      = 1'b1;
`ifdef SQRT_REQ_MASTER_TIMEOUT_EN
                    err_d       = 1'b0;
                    wdog_d      = 16'd0;
`endif
                    if (count == 8'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = SEND;
                        out_a_stb_d = 1'b1;
                        out_a_d     = (seed == 32'd0) ? 32'h00000001 : seed;
                    end
                end
            end

            SEND: begin
                if (out_a_ack) begin
                    out_a_stb_d = 1'b0;
                    operand_d   = out_a;
                    lfsr_d      = lfsr_next(lfsr);
                    state_d     = WAIT_RES;
`ifdef SQRT_REQ_MASTER_TIMEOUT_EN
                    wdog_d      = 16'd0;
                end else if (wdog_hit) begin
                    out_a_stb_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    wdog_d      = wdog + 16'd1;
`endif
                end
            end

            WAIT_RES: begin
                if (in_z_stb) begin
                    res_z_d     = in_z;
                    res_a_d     = operand;
                    res_valid_d = 1'b1;
                    in_z_ack_d  = 1'b1;
                    state_d     = ACK;
`ifdef SQRT_REQ_MASTER_TIMEOUT_EN
                end else if (wdog_hit) begin
                    err_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    wdog_d      = wdog + 16'd1;
`endif
                end
            end

            ACK: begin
                // remaining is at least 1 here; the guard keeps it from wrapping
                if (remaining != 8'd0) begin
                    remaining_d = remaining - 8'd1;
                end
                if (remaining <= 8'd1) begin
                    state_d = DONE;
                end else begin
                    state_d     = SEND;
                    out_a_stb_d = 1'b1;
                    out_a_d     = lfsr;
`ifdef SQRT_REQ_MASTER_TIMEOUT_EN
                    wdog_d      = 16'd0;
`endif
                end
            end

            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset forces everything idle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lfsr      <= 32'h00000001;
            operand   <= 32'd0;
            remaining <= 8'd0;
            out_a     <= 32'd0;
            out_a_stb <= 1'b0;
            in_z_ack  <= 1'b0;
            res_a     <= 32'd0;
            res_z     <= 32'd0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SQRT_REQ_MASTER_TIMEOUT_EN
            err       <= 1'b0;
            wdog      <= 16'd0;
`endif
        end else begin
            state     <= state_d;
            lfsr      <= lfsr_d;
            operand   <= operand_d;
            remaining <= remaining_d;
            out_a     <= out_a_d;
            out_a_stb <= out_a_stb_d;
            in_z_ack  <= in_z_ack_d;
            res_a     <= res_a_d;
            res_z     <= res_z_d;
            res_valid <= res_valid_d;
            busy      <= busy_d;
            done      <= done_d;
`ifdef SQRT_REQ_MASTER_TIMEOUT_EN
            err       <= err_d;
            wdog      <= wdog_d;
`endif
        end
    end

endmodule

// File: tb/tb_sqrt_req_master.sv
// tb_sqrt_req_master
// Scoreboard bench for sqrt_req_master. The stimulus side predicts the operand
// sequence of each run from the seed and queues it; a randomised responder
// plays the sqrt unit and queues the (operand, result) pairs it hands back;
// a monitor pops and compares whenever the DUT transfers an operand, pulses
// res_valid or pulses done.
module tb_sqrt_req_master;

    localparam logic [15:0] TMO = 16'd16;
`ifdef SQRT_REQ_MASTER_TIMEOUT_EN
    localparam int Z_DIRECTED = 8;
`else
    localparam int Z_DIRECTED = 20;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] z;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  count = 8'd0;
    logic [31:0] seed = 32'd0;
    logic [31:0] out_a;
    logic        out_a_stb;
    logic        out_a_ack;
    logic [31:0] in_z;
    logic        in_z_stb;
    logic        in_z_ack;
    logic [31:0] res_a, res_z;
    logic        res_valid, busy, done, err;

    logic [31:0] exp_a_q[$];
    logic [31:0] pair_a_q[$];
    pair_t       exp_res_q[$];
    logic        exp_done_q[$];

    int checks = 0;
    int errors = 0;

    int unsigned ack_lo = 0, ack_hi = 3, z_lo = 0, z_hi = 5;
    bit          resp_en = 1'b1;
    bit          spurious = 1'b0;
    bit          z_fixed_en = 1'b0;
    logic [31:0] z_fixed = 32'h3F800000;

    always #5 clk = ~clk;

    sqrt_req_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .seed      (seed),
        .out_a     (out_a),
        .out_a_stb (out_a_stb),
        .out_a_ack (out_a_ack),
        .in_z      (in_z),
        .in_z_stb  (in_z_stb),
        .in_z_ack  (in_z_ack),
        .res_a     (res_a),
        .res_z     (res_z),
        .res_valid (res_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Reference LFSR step: halve, and fold in the polynomial if a one fell out.
    function automatic logic [31:0] model_step(input logic [31:0] v);
        logic [31:0] s;
        s = v / 32'd2;
        if ((v % 32'd2) == 32'd1) s = s ^ 32'h80200003;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failEvent(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got unexpected event expected none", name);
    endtask

    task automatic flushQueues();
        exp_a_q.delete();
        pair_a_q.delete();
        exp_res_q.delete();
        exp_done_q.delete();
    endtask

    // Start a run and queue everything the run should produce.
    task automatic applyStimulus(input logic [7:0] cnt, input logic [31:0] sd, input logic timeout_expected);
        logic [31:0] s;
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        seed  = sd;
        count = cnt;
        start = 1'b1;
        if (!timeout_expected) begin
            s = (sd == 32'd0) ? 32'h00000001 : sd;
            for (int i = 0; i < int'(cnt); i++) begin
                exp_a_q.push_back(s);
                pair_a_q.push_back(s);
                s = model_step(s);
            end
        end
        exp_done_q.push_back(timeout_expected);
        @(negedge clk);
        start = 1'b0;
        count = 8'($urandom);
        seed  = $urandom;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (exp_done_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_done_q.size() != 0) begin
            failEvent("done_timeout");
            flushQueues();
        end
        repeat (2) @(negedge clk);
    endtask

    // Responder playing the sqrt unit with random handshake delays.
    initial begin : responder
        int          rstate;
        int unsigned dly;
        logic [31:0] a;
        logic [31:0] z;
        rstate    = 0;
        dly       = 0;
        out_a_ack = 1'b0;
        in_z_stb  = 1'b0;
        in_z      = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rstate    = 0;
                out_a_ack = 1'b0;
                in_z_stb  = 1'b0;
                dly       = $urandom_range(ack_hi, ack_lo);
            end else begin
                case (rstate)
                    0: begin
                        if (out_a_stb && resp_en) begin
                            if (spurious) begin
                                in_z_stb = 1'b1;
                                in_z     = $urandom;
                            end
                            if (dly == 0) begin
                                out_a_ack = 1'b1;
                                rstate    = 1;
                            end else begin
                                dly--;
                            end
                        end
                    end
                    1: begin
                        out_a_ack = spurious;
                        in_z_stb  = 1'b0;
                        dly       = $urandom_range(z_hi, z_lo);
                        rstate    = 2;
                    end
                    2: begin
                        if (dly == 0) begin
                            a = (pair_a_q.size() != 0) ? pair_a_q.pop_front() : 32'd0;
                            z = z_fixed_en ? z_fixed : $urandom;
                            in_z      = z;
                            in_z_stb  = 1'b1;
                            out_a_ack = 1'b0;
                            exp_res_q.push_back({a, z});
                            rstate    = 3;
                        end else begin
                            dly--;
                        end
                    end
                    default: begin
                        if (in_z_ack) begin
                            in_z_stb = 1'b0;
                            in_z     = $urandom;
                            dly      = $urandom_range(ack_hi, ack_lo);
                            rstate   = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: compares DUT events against the queued expectations.
    initial begin : monitor
        logic        prev_stb, prev_ack, prev_done, exp_err;
        logic [31:0] prev_a;
        pair_t       p;
        prev_stb  = 1'b0;
        prev_ack  = 1'b0;
        prev_done = 1'b0;
        prev_a    = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (prev_stb && !prev_ack && out_a_stb)
                    checkOutput("out_a_stable", out_a, prev_a);
                if (out_a_stb && out_a_ack) begin
                    if (exp_a_q.size() == 0) failEvent("extra_operand");
                    else checkOutput("out_a", out_a, exp_a_q.pop_front());
                end
                if (res_valid || in_z_ack)
                    checkOutput("res_valid_with_ack", {30'd0, res_valid, in_z_ack}, 32'd3);
                if (res_valid) begin
                    if (exp_res_q.size() == 0) begin
                        failEvent("extra_result");
                    end else begin
                        p = exp_res_q.pop_front();
                        checkOutput("res_a", res_a, p.a);
                        checkOutput("res_z", res_z, p.z);
                    end
                end
                if (done) begin
                    checkOutput("done_width", {31'd0, prev_done}, 32'd0);
                    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
                    checkOutput("operands_left", 32'(exp_a_q.size()), 32'd0);
                    if (exp_done_q.size() == 0) begin
                        failEvent("unexpected_done");
                    end else begin
                        exp_err = exp_done_q.pop_front();
                        checkOutput("err_at_done", {31'd0, err}, {31'd0, exp_err});
                    end
                end
                prev_stb  = out_a_stb;
                prev_ack  = out_a_ack;
                prev_done = done;
                prev_a    = out_a;
            end else begin
                prev_stb  = 1'b0;
                prev_ack  = 1'b0;
                prev_done = 1'b0;
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_out_a"}, out_a, 32'd0);
        checkOutput({tag, "_out_a_stb"}, {31'd0, out_a_stb}, 32'd0);
        checkOutput({tag, "_in_z_ack"}, {31'd0, in_z_ack}, 32'd0);
        checkOutput({tag, "_res_a"}, res_a, 32'd0);
        checkOutput({tag, "_res_z"}, res_z, 32'd0);
        checkOutput({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    // Directed scenarios followed by randomised runs.
    initial begin : stimulus
        int n;
        #2;
        checkAllZero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] empty run");
        applyStimulus(8'd0, 32'h12345678, 1'b0);
        checkOutput("count0_no_stb", {31'd0, out_a_stb}, 32'd0);
        waitDone(50);

        $display("[TB] directed seed=1 count=2");
        ack_lo = 3; ack_hi = 3; z_lo = Z_DIRECTED; z_hi = Z_DIRECTED; z_fixed_en = 1'b1;
        applyStimulus(8'd2, 32'h00000001, 1'b0);
        checkOutput("start_latency", {31'd0, out_a_stb}, 32'd1);
        checkOutput("first_operand", out_a, 32'h00000001);
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        waitDone(200);
        checkOutput("last_res_a", res_a, 32'h80200003);
        checkOutput("last_res_z", res_z, 32'h3F800000);
        z_fixed_en = 1'b0;

        $display("[TB] zero seed");
        ack_lo = 0; ack_hi = 2; z_lo = 0; z_hi = 4;
        applyStimulus(8'd1, 32'h00000000, 1'b0);
        waitDone(100);
        checkOutput("zero_seed_res_a", res_a, 32'h00000001);

        $display("[TB] start and in_z_stb while busy");
        spurious = 1'b1;
        applyStimulus(8'd3, $urandom, 1'b0);
        repeat (3) @(negedge clk);
        count = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(300);
        spurious = 1'b0;

`ifdef SQRT_REQ_MASTER_TIMEOUT_EN
        $display("[TB] watchdog");
        resp_en = 1'b0;
        applyStimulus(8'd3, $urandom, 1'b1);
        n = 0;
        while (out_a_stb && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        checkOutput("timeout_stb_cycles", n, 32'd16);
        waitDone(50);
        checkOutput("err_sticky", {31'd0, err}, 32'd1);
        resp_en = 1'b1;
        applyStimulus(8'd1, $urandom, 1'b0);
        checkOutput("err_cleared", {31'd0, err}, 32'd0);
        waitDone(100);
`endif

        $display("[TB] random runs");
        for (int r = 0; r < 10; r++) begin
            ack_lo = 0; ack_hi = $urandom_range(4, 0);
            z_lo = 0; z_hi = $urandom_range(6, 0);
            applyStimulus(8'($urandom_range(6, 0)), ((r % 4) == 3) ? 32'd0 : $urandom, 1'b0);
            waitDone(600);
        end

        $display("[TB] count 255");
        ack_lo = 0; ack_hi = 1; z_lo = 0; z_hi = 2;
        applyStimulus(8'hFF, $urandom, 1'b0);
        waitDone(255 * 30);

        $display("[TB] reset during WAIT_RES");
        z_lo = 10; z_hi = 10;
        applyStimulus(8'd4, $urandom, 1'b0);
        n = 0;
        while (out_a_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_wait_res", {31'd0, out_a_stb}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkAllZero("midrun_reset");
        flushQueues();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("post_reset_stb", {31'd0, out_a_stb}, 32'd0);

        ack_lo = 0; ack_hi = 2; z_lo = 0; z_hi = 3;
        applyStimulus(8'd2, $urandom, 1'b0);
        waitDone(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule

// File: doc/sqrt_req_master.md
SQRT_REQ_MASTER -- requirements
Module: sqrt_req_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16'd65535, watchdog limit in clock cycles per handshake wait; used only when SQRT_REQ_MASTER_TIMEOUT_EN is defined.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 start  in  1  one-cycle request to begin a run; ignored while busy=1.
REQ-005 count  in  8  number of operands in the run; sampled with start.
REQ-006 seed  in  32  LFSR seed; sampled with start.
REQ-007 out_a  out  32  operand to sqrt unit (input_a side).
REQ-008 out_a_stb  out  1  operand valid.
REQ-009 out_a_ack  in  1  sqrt unit accepts operand.
REQ-010 in_z  in  32  result from sqrt unit.
REQ-011 in_z_stb  in  1  result valid.
REQ-012 in_z_ack  out  1  result accepted.
REQ-013 res_a, res_z  out  32 each  operand/result pair of the last completed transaction.
REQ-014 res_valid  out  1  one-cycle pulse when res_a/res_z update.
REQ-015 busy  out  1  run in progress; done  out  1  one-cycle end-of-run pulse; err  out  1  sticky timeout flag.

Function
REQ-016 FSM states: IDLE, SEND, WAIT_RES, ACK, DONE; all outputs registered.
REQ-017 IDLE: start=1 loads lfsr<=seed (32'h00000001 if seed==0), remaining<=count, err<=0, busy<=1; next DONE if count==0, else SEND.
REQ-018 SEND: out_a_stb=1, out_a=lfsr, both held stable until out_a_ack=1 is sampled.
REQ-019 Operand transfer = cycle with out_a_stb && out_a_ack; next cycle out_a_stb=0, operand latched for res_a, lfsr advanced, state WAIT_RES.
REQ-020 LFSR: Galois right-shift, polynomial 32'h80200003: next = lsb ? (lfsr>>1)^32'h80200003 : lfsr>>1.
REQ-021 WAIT_RES: in_z_ack=0; on in_z_stb=1 sampled: res_z<=in_z, res_a<=latched operand, res_valid pulse, in_z_ack<=1, state ACK.
REQ-022 ACK: in_z_ack=1 for exactly one cycle, then 0; remaining decremented; next DONE if remaining reaches 0, else SEND.
REQ-023 in_z_stb outside WAIT_RES ignored; in_z_ack never asserted outside ACK.
REQ-024 out_a_ack outside SEND ignored.
REQ-025 DONE: done=1 one cycle, busy<=0, state IDLE; start in the DONE cycle ignored.
REQ-026 Count 8'hFF supported; remaining never wraps.
REQ-027 Minimum latency start->first out_a_stb: 1 cycle; ACK->next out_a_stb: 1 cycle.

Reset
REQ-028 rst=0 immediately forces state IDLE, out_a=0, out_a_stb=0, in_z_ack=0, res_a=0, res_z=0, res_valid=0, busy=0, done=0, err=0, lfsr=32'h00000001, remaining=0, independent of clk.
REQ-029 Reset mid-run aborts it; no done pulse; the first operation after release requires a new start.

Configuration
REQ-030 Macro SQRT_REQ_MASTER_TIMEOUT_EN defined: 16-bit watchdog cleared on entry to SEND/WAIT_RES; on reaching TIMEOUT_CYCLES, out_a_stb<=0, in_z_ack<=0, err<=1, state DONE.
REQ-031 Macro undefined: no watchdog logic, err tied 0, SEND/WAIT_RES wait indefinitely.

Verification
REQ-032 count=0, start -> no out_a_stb, done pulse one cycle after DONE entry, busy returns 0, res_valid never pulses.
REQ-033 seed=0x00000001, count=2, responder acks 3 cycles after stb, returns z=0x3F800000 20 cycles later -> out_a=0x00000001 then 0x80200003; two res_valid pulses; res_a/res_z=0x00000001/0x3F800000 after the first; in_z_ack high exactly 1 cycle each; one done pulse.
REQ-034 seed=0, count=1 -> out_a=0x00000001.
REQ-035 Start re-pulsed while busy, and in_z_stb raised during SEND -> both ignored; no extra operands; in_z_ack stays 0.
REQ-036 TIMEOUT_EN defined, TIMEOUT_CYCLES=16, out_a_ack held 0 -> out_a_stb drops after 16 cycles, err=1, done pulse; next start clears err.
REQ-037 rst=0 asserted mid-WAIT_RES between clock edges -> all outputs 0 before next edge; no done pulse.
